// File: rtl/spi_master.sv
// Single-channel SPI master: one full-duplex BIT_WIDTH-bit transfer per start pulse,
// all four CPOL/CPHA modes, MSB- or LSB-first, sclk divided down from clk.
module spi_master #(
    parameter int unsigned BIT_WIDTH = 8,
    parameter int unsigned CLK_DIV   = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 cpol,
    input  logic                 cpha,
    input  logic                 lsbf,
    input  logic [BIT_WIDTH-1:0] wdata,
    input  logic                 miso,
    output logic                 sclk,
    output logic                 nss,
    output logic                 mosi,
    output logic                 done,
    output logic [BIT_WIDTH-1:0] rdata
);

    localparam int unsigned H      = CLK_DIV / 2;
    localparam int unsigned CNT_W  = $clog2(H + 1);
    localparam int unsigned NHALF  = 2 * BIT_WIDTH;
    localparam int unsigned HALF_W = $clog2(NHALF + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]           state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [HALF_W-1:0]    half_q;
    logic                 cpol_q, cpha_q, lsbf_q;
    logic [BIT_WIDTH-1:0] tx_q, rx_q, rdata_q;
    logic                 sclk_q, nss_q, mosi_q, done_q;

    logic                 cnt_end;
    logic                 edge_now, edge_lead, edge_last;
    logic [HALF_W-1:0]    edge_idx;
    logic                 tx_bit;
    logic [BIT_WIDTH-1:0] tx_shift, rx_shift;

    always_comb begin
        cnt_end  = (cnt_q == CNT_W'(H - 1));
        edge_idx = (state_q == S_SETUP) ? '0 : half_q + HALF_W'(1);
        // An sclk edge is due at the end of SETUP and of every half period but the last
        edge_now = cnt_end && ((state_q == S_SETUP) ||
                   (state_q == S_SHIFT && half_q != HALF_W'(NHALF - 1)));
        edge_lead = ~edge_idx[0];
        edge_last = (edge_idx == HALF_W'(NHALF - 1));
    end

    always_comb begin
        tx_bit   = lsbf_q ? tx_q[0] : tx_q[BIT_WIDTH-1];
        tx_shift = tx_q;
        rx_shift = rx_q;
        if (lsbf_q) begin
            for (int i = 0; i < int'(BIT_WIDTH) - 1; i++) begin
                tx_shift[i] = tx_q[i+1];
                rx_shift[i] = rx_q[i+1];
            end
            tx_shift[BIT_WIDTH-1] = 1'b0;
            rx_shift[BIT_WIDTH-1] = miso;
        end else begin
            for (int i = int'(BIT_WIDTH) - 1; i > 0; i--) begin
                tx_shift[i] = tx_q[i-1];
                rx_shift[i] = rx_q[i-1];
            end
            tx_shift[0] = 1'b0;
            rx_shift[0] = miso;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            half_q  <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            lsbf_q  <= 1'b0;
            tx_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            sclk_q  <= 1'b0;
            nss_q   <= 1'b1;
            mosi_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    nss_q  <= 1'b1;
                    mosi_q <= 1'b0;
                    sclk_q <= cpol_q;
                    if (start) begin
                        cpol_q  <= cpol;
                        cpha_q  <= cpha;
                        lsbf_q  <= lsbf;
                        tx_q    <= wdata;
                        rx_q    <= '0;
                        sclk_q  <= cpol;
                        nss_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    // cpha=0 slaves sample on the first edge, so the first bit goes out now
                    if (cnt_q == '0 && !cpha_q) begin
                        mosi_q <= tx_bit;
                        tx_q   <= tx_shift;
                    end
                    if (cnt_end) begin
                        cnt_q   <= '0;
                        half_q  <= '0;
                        state_q <= S_SHIFT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_SHIFT: begin
                    if (cnt_end) begin
                        cnt_q <= '0;
                        if (half_q == HALF_W'(NHALF - 1)) begin
                            sclk_q  <= cpol_q;
                            state_q <= S_HOLD;
                        end else begin
                            half_q <= half_q + HALF_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (cnt_end) begin
                        cnt_q   <= '0;
                        nss_q   <= 1'b1;
                        mosi_q  <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    rdata_q <= rx_q;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase

            if (edge_now) begin
                sclk_q <= ~sclk_q;
                if (edge_lead != cpha_q) begin
                    rx_q <= rx_shift;
                end else if (!edge_last) begin
                    mosi_q <= tx_bit;
                    tx_q   <= tx_shift;
                end
            end
        end
    end

    assign sclk  = sclk_q;
    assign nss   = nss_q;
    assign mosi  = mosi_q;
    assign done  = done_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_spi_master.sv
// Randomized bench for spi_master: each transfer is watched cycle by cycle and compared
// against bit order, frame timing and received word derived from the mode settings.
module tb_spi_master;

    localparam int BW  = 8;
    localparam int DIV = 20;
    localparam int H   = DIV / 2;
    localparam int NSS_LOW = (2 * BW + 2) * H;

    logic          clk = 1'b0;
    logic          rst_n, start, cpol, cpha, lsbf;
    logic [BW-1:0] wdata, rdata;
    logic          sclk, nss, mosi, done;
    logic          miso, loop_en, fix_val;

    int n_checks = 0;
    int n_errors = 0;

    assign miso = loop_en ? mosi : fix_val;

    always #5 clk = ~clk;

    spi_master #(.BIT_WIDTH(BW), .CLK_DIV(DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .cpol  (cpol),
        .cpha  (cpha),
        .lsbf  (lsbf),
        .wdata (wdata),
        .miso  (miso),
        .sclk  (sclk),
        .nss   (nss),
        .mosi  (mosi),
        .done  (done),
        .rdata (rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One transfer; the slave either loops mosi back or drives a constant level.
    task automatic run_xfer(input logic [BW-1:0] w, input logic pol, input logic pha,
                            input logic lsb, input logic lp, input logic fv,
                            input logic disturb);
        logic [BW-1:0] exp_r, exp_seq, got_seq, rd_before;
        int            nss_low, rises, dones, done_k, viol, nbits, rd_chg;
        logic          prev_sclk, prev_mosi, samp_edge;
        nss_low = 0; rises = 0; dones = 0; done_k = -1; viol = 0; nbits = 0; rd_chg = 0;
        got_seq = '0; prev_sclk = 1'b0; prev_mosi = 1'b0;
        rd_before = rdata;
        loop_en = lp; fix_val = fv;
        wdata = w; cpol = pol; cpha = pha; lsbf = lsb; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (disturb && k == 50) begin
                start = 1'b1; cpol = ~pol; cpha = ~pha; lsbf = ~lsb; wdata = ~w;
            end
            if (disturb && k == 51) start = 1'b0;
            if (!nss) nss_low++;
            if (done) begin
                dones++;
                if (done_k < 0) done_k = k;
            end
            if (done_k < 0 && rdata !== rd_before) rd_chg++;
            if (k == 0) begin
                check("setup_sclk", 32'(sclk), 32'(pol));
            end else if (sclk != prev_sclk) begin
                if (sclk && !prev_sclk) rises++;
                samp_edge = pha ? (sclk == pol) : (sclk != pol);
                if (samp_edge) begin
                    if (nbits < BW) got_seq[nbits] = prev_mosi;
                    nbits++;
                    if (mosi != prev_mosi) viol++;
                end
            end
            prev_sclk = sclk;
            prev_mosi = mosi;
            if (done_k >= 0 && k >= done_k + 2) break;
        end
        for (int i = 0; i < BW; i++) exp_seq[i] = lsb ? w[i] : w[BW-1-i];
        exp_r = lp ? w : {BW{fv}};
        check("nss_low_time", 32'(nss_low), 32'(NSS_LOW));
        check("sclk_rises", 32'(rises), 32'(BW));
        check("sample_edges", 32'(nbits), 32'(BW));
        check("mosi_order", 32'(got_seq), 32'(exp_seq));
        check("mosi_on_sample_edge", 32'(viol), 32'd0);
        check("done_count", 32'(dones), 32'd1);
        check("done_latency", 32'(done_k), 32'(NSS_LOW + 1));
        check("rdata_stable", 32'(rd_chg), 32'd0);
        check("rdata", 32'(rdata), 32'(exp_r));
        check("sclk_idle", 32'(sclk), 32'(pol));
        check("nss_idle", 32'(nss), 32'd1);
        check("mosi_idle", 32'(mosi), 32'd0);
    endtask

    task automatic reset_mid_xfer();
        int dones;
        loop_en = 1'b1; fix_val = 1'b0;
        wdata = 8'hFF; cpol = 1'b1; cpha = 1'b0; lsbf = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (61) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_nss", 32'(nss), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 250; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("rst_no_done", 32'(dones), 32'd0);
        check("rst_nss_idle", 32'(nss), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; cpol = 1'b0; cpha = 1'b0; lsbf = 1'b0;
        wdata = '0; loop_en = 1'b1; fix_val = 1'b0;
        #23;
        check("por_nss", 32'(nss), 32'd1);
        check("por_sclk", 32'(sclk), 32'd0);
        check("por_mosi", 32'(mosi), 32'd0);
        check("por_done", 32'(done), 32'd0);
        check("por_rdata", 32'(rdata), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_xfer(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_xfer(8'h56, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int m = 1; m < 4; m++) begin
            for (int l = 0; l < 2; l++) begin
                run_xfer(8'h34, 1'(m >> 1), 1'(m), 1'(l), 1'b1, 1'b0, 1'b0);
                run_xfer(8'h78, 1'(m >> 1), 1'(m), 1'(l), 1'b1, 1'b0, 1'b0);
            end
        end
        run_xfer(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        run_xfer(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_xfer(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        run_xfer(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        reset_mid_xfer();
        run_xfer(8'h9E, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int r = 0; r < 10; r++) begin
            run_xfer(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Single-channel SPI master. Runs one full-duplex BIT_WIDTH-bit transfer per start pulse.
- Supports all four CPOL/CPHA modes and MSB-first or LSB-first bit order.
- Sits between a local register/control interface and an external SPI slave.
- Generates sclk from the system clock via an integer divider; drives nss for the whole transfer.

Parameters:
- BIT_WIDTH, 8, bits per transfer (>=1).
- CLK_DIV, 20, system clocks per sclk period. Must be even and >=4. Half period H = CLK_DIV/2.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  transfer request; sampled when idle.
- cpol  in  1  sclk idle level.
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge.
- lsbf  in  1  1: LSB first; 0: MSB first.
- wdata  in  BIT_WIDTH  data to transmit.
- miso  in  1  serial data from slave.
- sclk  out  1  SPI clock.
- nss  out  1  active-low slave select.
- mosi  out  1  serial data to slave.
- done  out  1  one-cycle pulse at end of transfer.
- rdata  out  BIT_WIDTH  last received word.

Behaviour:
- Reset (async, rst_n=0): nss=1, sclk=0, mosi=0, done=0, rdata=0; state IDLE; counters cleared.
- IDLE:
  - nss=1, mosi=0, sclk follows registered cpol.
  - start=1 on a clock edge latches wdata, cpol, cpha and lsbf into internal registers. The transfer uses only the latched values.
  - On that edge, go to SETUP.
- Inputs during a transfer: start is ignored while not IDLE; changes to cpol, cpha, lsbf and wdata have no effect until the next start.
- SETUP (H clocks):
  - nss=0, sclk=cpol.
  - If cpha=0, mosi presents the first bit: wdata[BIT_WIDTH-1] when lsbf=0, wdata[0] when lsbf=1.
- SHIFT (2*BIT_WIDTH half periods of H clocks each): sclk toggles at the start of each half period.
  - cpha=0:
    - Leading edge: sample miso.
    - Trailing edge: mosi advances to the next bit, except after the final trailing edge.
  - cpha=1:
    - Leading edge: mosi presents the next bit (first bit on the first leading edge).
    - Trailing edge: sample miso.
- Shift order: received bits fill rdata from MSB down when lsbf=0, or from LSB up when lsbf=1, so rdata matches the slave's word.
- HOLD (H clocks): sclk returns to and stays at cpol; nss stays 0; mosi holds its last bit.
- End of HOLD, single clock:
  - nss=1, rdata updated with the received word, done=1 for exactly one clock.
  - Return to IDLE; mosi returns to 0.
- rdata is stable between transfers; it changes only on the done cycle.
- Timing:
  - nss low time = (2*BIT_WIDTH+2)*H clocks (180 clocks for defaults).
  - Latency from start-accept edge to done = (2*BIT_WIDTH+2)*H + 1 clocks.
- Back-to-back: start may be accepted in the clock after done. nss is then high for at least 1 clock.
- A reset mid-transfer aborts immediately to the reset values. No done is issued.
- All outputs are registered (glitch-free sclk, nss, mosi).

Test Plan:
- Mode 0, lsbf=0, wdata=0x12, miso looped from mosi:
  - nss low 180 clocks; 8 rising sclk edges, sclk idle 0.
  - mosi bits 0,0,0,1,0,0,1,0 stable at each rising edge.
  - done one-cycle pulse; rdata=0x12.
- Mode 0, lsbf=1, wdata=0x56, loopback: mosi order 0,1,1,0,1,0,1,0; rdata=0x56.
- Modes 1, 2, 3 (cpol/cpha = 0/1, 1/0, 1/1), wdata=0x34 and 0x78, loopback, both lsbf values:
  - sclk idles at cpol.
  - mosi changes only on non-sampling edges.
  - rdata equals wdata each time.
- Fixed miso=1 for a whole transfer -> rdata=all ones; fixed miso=0 -> rdata=0.
- Pulse start and toggle cpol/wdata mid-transfer:
  - Transfer is unaffected; exactly one done.
  - A second start issued after done gives a second correct transfer.
- Assert rst_n=0 during SHIFT:
  - nss=1, sclk=0, mosi=0, done=0, rdata=0 immediately; no done pulse.
  - Next start works normally.
